// File: rtl/bitty_fetch_seq.sv
// -----------------------------------------------------------------------------
// bitty_fetch_seq
//
// Instruction-fetch sequencer for the Bitty core. Walks PC -> memory read ->
// core execute -> PC update, with a configurable memory read latency, a
// branch-aware PC update, single-step mode, a HALT opcode, a watchdog on
// core_done and a retired-instruction counter.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   run           in   level enable (free-run) / step trigger (step mode)
//   step_mode     in   1 = one instruction per run rising edge
//   mem_addr      out  program memory read address (always equals pc)
//   mem_rd        out  read strobe, first FETCH cycle only
//   mem_rdata     in   read data, valid MEM_LAT cycles after mem_rd
//   instr         out  latched instruction presented to the core
//   instr_valid   out  one-cycle start pulse to the core
//   core_done     in   core finished the current instruction
//   branch_taken  in   sampled together with core_done
//   branch_pc     in   branch target, sampled together with core_done
//   pc            out  current program counter
//   busy          out  sequencing an instruction (not IDLE, not HALT)
//   halted        out  in the sticky HALT state
//   err           out  HALT was caused by the core_done watchdog
//   retired       out  count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module bitty_fetch_seq #(
    parameter int                 ADDR_W     = 8,
    parameter int                 INSTR_W    = 16,
    parameter int                 MEM_LAT    = 1,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF,
    parameter int                 TIMEOUT    = 255,
    parameter int                 CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step_mode,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               core_done,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_HALT
    } state_t;

    // Latency counter spans 0..MEM_LAT; the read data is captured on the
    // cycle the counter reaches MEM_LAT.
    localparam int               LAT_W    = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);
    // Watchdog counts completed WAIT cycles; TIMEOUT-1 on the current cycle
    // means this is the TIMEOUT-th WAIT cycle without core_done.
    localparam int               WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LAT_W-1:0]     r_lat_cnt;
    logic [WD_W-1:0]      r_wd_cnt;
    logic [ADDR_W-1:0]    r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic [CNT_W-1:0]     r_retired;
    logic                 r_err;
    logic                 r_run_prev;

    logic                 w_fetch_done;
    logic                 w_retire;
    logic                 w_timeout;
    logic                 w_start;

    assign w_fetch_done = (r_state == S_FETCH) && (r_lat_cnt == LAT_LAST);
    assign w_retire     = (r_state == S_WAIT) && core_done;
    // core_done wins over the watchdog when both land on the same cycle.
    assign w_timeout    = (r_state == S_WAIT) && !core_done && (r_wd_cnt == WD_LAST);
    assign w_start      = step_mode ? (run && !r_run_prev) : run;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        mem_rd      = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy   = 1'b1;
                mem_rd = (r_lat_cnt == '0);
                if (w_fetch_done) begin
                    w_state_nxt = (mem_rdata == HALT_INSTR) ? S_HALT : S_EXEC;
                end
            end
            S_EXEC: begin
                busy        = 1'b1;
                instr_valid = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (w_retire) begin
                    // run falling mid-instruction lands here: finish, then IDLE.
                    w_state_nxt = (run && !step_mode) ? S_FETCH : S_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: PC, instruction latch, counters, error flag
    // ------------------------------------------------------------------
    // NOTE: all datapath registers are reset, including instr, so the core
    // never sees stale data straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat_cnt  <= '0;
            r_wd_cnt   <= '0;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_retired  <= '0;
            r_err      <= 1'b0;
            r_run_prev <= 1'b0;
        end else begin
            r_run_prev <= run;

            // Counter only advances inside FETCH; it is zero on FETCH entry.
            if ((r_state == S_FETCH) && !w_fetch_done) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end else begin
                r_lat_cnt <= '0;
            end

            if (w_fetch_done) begin
                r_instr <= mem_rdata;
            end

            // Cleared everywhere except while waiting without core_done, so
            // it starts at zero on every WAIT entry.
            if ((r_state == S_WAIT) && !core_done) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end

            if (w_retire) begin
                r_pc      <= branch_taken ? branch_pc : r_pc + 1'b1;
                r_retired <= r_retired + 1'b1;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign instr    = r_instr;
    assign retired  = r_retired;
    assign err      = r_err;

endmodule

// File: tb/tb_bitty_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_bitty_fetch_seq
//
// Directed bench for bitty_fetch_seq. Instance u_dut (MEM_LAT=1) exercises
// free-run, branch/wrap, HALT opcode, watchdog and step mode; instance
// u_dut_b (MEM_LAT=3) exercises the longer read latency. Expected
// instructions for u_dut are queued when stimulus is issued and popped by a
// monitor whenever instr_valid is seen.
// -----------------------------------------------------------------------------
module tb_bitty_fetch_seq;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    logic        clk;
    logic        reset;

    // u_dut signals
    logic        run;
    logic        step_mode;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        core_done;
    logic        branch_taken;
    logic [7:0]  branch_pc;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    // u_dut_b signals
    logic        run_b;
    logic        step_mode_b;
    logic [7:0]  mem_addr_b;
    logic        mem_rd_b;
    logic [15:0] mem_rdata_b;
    logic [15:0] instr_b;
    logic        instr_valid_b;
    logic        core_done_b;
    logic        branch_taken_b;
    logic [7:0]  branch_pc_b;
    logic [7:0]  pc_b;
    logic        busy_b;
    logic        halted_b;
    logic        err_b;
    logic [15:0] retired_b;

    logic [15:0] mem [256];
    exp_t        sb_q[$];
    int          valid_cyc[$];
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          core_delay;
    logic        core_en;

    bitty_fetch_seq #(.MEM_LAT(1), .TIMEOUT(255)) u_dut (
        .clk(clk), .reset(reset), .run(run), .step_mode(step_mode),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .core_done(core_done),
        .branch_taken(branch_taken), .branch_pc(branch_pc), .pc(pc),
        .busy(busy), .halted(halted), .err(err), .retired(retired)
    );

    bitty_fetch_seq #(.MEM_LAT(3), .TIMEOUT(255)) u_dut_b (
        .clk(clk), .reset(reset), .run(run_b), .step_mode(step_mode_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata_b),
        .instr(instr_b), .instr_valid(instr_valid_b), .core_done(core_done_b),
        .branch_taken(branch_taken_b), .branch_pc(branch_pc_b), .pc(pc_b),
        .busy(busy_b), .halted(halted_b), .err(err_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_pc"},          pc,          32'h0);
        check({p, "_mem_addr"},    mem_addr,    32'h0);
        check({p, "_mem_rd"},      mem_rd,      32'h0);
        check({p, "_instr"},       instr,       32'h0);
        check({p, "_instr_valid"}, instr_valid, 32'h0);
        check({p, "_busy"},        busy,        32'h0);
        check({p, "_halted"},      halted,      32'h0);
        check({p, "_err"},         err,         32'h0);
        check({p, "_retired"},     retired,     32'h0);
    endtask

    // Two reset edges, returns at a negedge with reset still asserted.
    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        run       = 1'b0;
        run_b     = 1'b0;
        step_mode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [15:0] i, input logic [7:0] p);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        return e;
    endfunction

    // Memory models and core models, updated 1 time unit after each edge.
    // Read data is 16'hDEAD outside its valid cycle so a capture at the wrong
    // latency shows up as a wrong instruction.
    initial begin : drivers
        logic        va;
        logic [7:0]  aa;
        logic        vb [3];
        logic [7:0]  ab [3];
        logic        c_pend;
        int          c_cnt;
        logic [15:0] c_instr;
        logic        b_pend;
        va = 1'b0; aa = '0; c_pend = 1'b0; c_cnt = 0; c_instr = '0; b_pend = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vb[k] = 1'b0;
            ab[k] = '0;
        end
        mem_rdata = 16'hDEAD; mem_rdata_b = 16'hDEAD;
        core_done = 1'b0; branch_taken = 1'b0; branch_pc = '0;
        core_done_b = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_rdata = (va === 1'b1) ? mem[aa] : 16'hDEAD;
            va = mem_rd;
            aa = mem_addr;

            mem_rdata_b = (vb[2] === 1'b1) ? mem[ab[2]] : 16'hDEAD;
            vb[2] = vb[1]; ab[2] = ab[1];
            vb[1] = vb[0]; ab[1] = ab[0];
            vb[0] = mem_rd_b; ab[0] = mem_addr_b;

            // Core A: done core_delay cycles after instr_valid; opcode B0xx
            // is a taken branch to xx.
            core_done    = 1'b0;
            branch_taken = 1'b0;
            branch_pc    = '0;
            if (c_pend) begin
                c_cnt--;
                if (c_cnt == 0) begin
                    c_pend    = 1'b0;
                    core_done = core_en;
                    if (c_instr[15:8] == 8'hB0) begin
                        branch_taken = 1'b1;
                        branch_pc    = c_instr[7:0];
                    end
                end
            end
            if (instr_valid === 1'b1) begin
                c_pend  = 1'b1;
                c_cnt   = core_delay;
                c_instr = instr;
            end

            // Core B: done the cycle after instr_valid, never branches.
            core_done_b = b_pend;
            b_pend      = (instr_valid_b === 1'b1);
        end
    end

    // Scoreboard monitor for u_dut.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                valid_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: instr_valid with instr %0h pc %0h, none queued", instr, pc);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_instr",    instr,    e.instr);
                    check("sb_pc",       pc,       e.pc);
                    check("sb_mem_addr", mem_addr, e.pc);
                end
            end
        end
    end

    initial begin : timeout_guard
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

    initial begin : main
        int rd_cyc;
        int v_cyc;
        int h_cyc;
        n_checks = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; run = 1'b0; step_mode = 1'b0;
        run_b = 1'b0; step_mode_b = 1'b0; branch_taken_b = 1'b0; branch_pc_b = '0;
        core_delay = 1; core_en = 1'b1;
        for (int k = 0; k < 256; k++) mem[k] = 16'h0BAD;

        // ---- Free run, two instructions then HALT opcode ----
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hFFFF;
        apply_reset();
        check_reset_vals("rst1");
        reset = 1'b0;
        valid_cyc.delete();
        sb_q.push_back(mk(16'h1234, 8'h00));
        sb_q.push_back(mk(16'h5678, 8'h01));
        run = 1'b1;
        for (int i = 0; i < 60 && halted !== 1'b1; i++) @(negedge clk);
        check("s1_halted",  halted,  32'h1);
        check("s1_err",     err,     32'h0);
        check("s1_pc",      pc,      32'h2);
        check("s1_retired", retired, 32'h2);
        check("s1_busy",    busy,    32'h0);
        check("s1_sb_left", sb_q.size(), 32'h0);
        check("s1_valid_gap", (valid_cyc.size() >= 2) ? valid_cyc[1] - valid_cyc[0] : 0, 32'd4);
        run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        repeat (6) @(negedge clk);
        check("s1_sticky_halted",  halted,  32'h1);
        check("s1_sticky_pc",      pc,      32'h2);
        check("s1_sticky_retired", retired, 32'h2);
        check("s1_sticky_valids",  valid_cyc.size(), 32'h2);

        // ---- Branch to 0x40, branch to 0xFF, fall-through wrap to 0x00 ----
        mem[0] = 16'hB040; mem[8'h40] = 16'hB0FF; mem[8'hFF] = 16'h1111;
        apply_reset();
        reset = 1'b0;
        valid_cyc.delete();
        sb_q.push_back(mk(16'hB040, 8'h00));
        sb_q.push_back(mk(16'hB0FF, 8'h40));
        sb_q.push_back(mk(16'h1111, 8'hFF));
        run = 1'b1;
        for (int i = 0; i < 40 && retired !== 16'd2; i++) @(negedge clk);
        check("s2_pc_after_branch", pc, 32'hFF);
        run = 1'b0;  // current instruction still completes
        for (int i = 0; i < 40 && retired !== 16'd3; i++) @(negedge clk);
        check("s2_retired",  retired, 32'h3);
        check("s2_pc_wrap",  pc,      32'h0);
        check("s2_busy",     busy,    32'h0);
        repeat (6) @(negedge clk);
        check("s2_idle_pc",      pc,      32'h0);
        check("s2_idle_retired", retired, 32'h3);
        check("s2_idle_mem_rd",  mem_rd,  32'h0);
        check("s2_sb_left",      sb_q.size(), 32'h0);

        // ---- Watchdog: core never answers ----
        mem[0] = 16'h2222;
        apply_reset();
        reset = 1'b0;
        valid_cyc.delete();
        core_en = 1'b0;
        sb_q.push_back(mk(16'h2222, 8'h00));
        run = 1'b1;
        h_cyc = 0;
        for (int i = 0; i < 400 && halted !== 1'b1; i++) @(negedge clk);
        h_cyc = cyc;
        check("s3_halted",  halted,  32'h1);
        check("s3_err",     err,     32'h1);
        check("s3_pc",      pc,      32'h0);
        check("s3_retired", retired, 32'h0);
        check("s3_wait_cycles", (valid_cyc.size() >= 1) ? h_cyc - valid_cyc[0] : 0, 32'd256);
        core_en = 1'b1;

        // ---- Step mode, then reset in the middle of WAIT ----
        mem[0] = 16'h3333; mem[1] = 16'h4444; mem[2] = 16'h5555;
        apply_reset();
        reset = 1'b0;
        step_mode = 1'b1;
        sb_q.push_back(mk(16'h3333, 8'h00));
        run = 1'b1;
        repeat (15) @(negedge clk);
        check("s4_step1_retired", retired, 32'h1);
        check("s4_step1_pc",      pc,      32'h1);
        check("s4_step1_busy",    busy,    32'h0);
        run = 1'b0;
        @(negedge clk);
        sb_q.push_back(mk(16'h4444, 8'h01));
        run = 1'b1;
        repeat (15) @(negedge clk);
        check("s4_step2_retired", retired, 32'h2);
        check("s4_step2_pc",      pc,      32'h2);
        core_delay = 3;
        run = 1'b0;
        @(negedge clk);
        sb_q.push_back(mk(16'h5555, 8'h02));
        run = 1'b1;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) @(negedge clk);
        check("s4_step3_valid", instr_valid, 32'h1);
        @(negedge clk);
        check("s4_in_wait_busy",    busy,    32'h1);
        check("s4_in_wait_retired", retired, 32'h2);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_wait");
        reset = 1'b0;
        step_mode = 1'b0;
        core_delay = 1;
        repeat (5) @(negedge clk);
        check("s4_post_retired", retired, 32'h0);
        check("s4_post_busy",    busy,    32'h0);
        check("s4_sb_left",      sb_q.size(), 32'h0);

        // ---- MEM_LAT = 3 instance ----
        mem[0] = 16'h9ABC;
        rd_cyc = 0;
        v_cyc  = 0;
        run_b = 1'b1;
        for (int i = 0; i < 10 && mem_rd_b !== 1'b1; i++) @(negedge clk);
        rd_cyc = cyc;
        check("s5_mem_rd", mem_rd_b, 32'h1);
        for (int i = 0; i < 20 && instr_valid_b !== 1'b1; i++) @(negedge clk);
        v_cyc = cyc;
        run_b = 1'b0;
        check("s5_valid",     instr_valid_b,  32'h1);
        check("s5_valid_gap", v_cyc - rd_cyc, 32'd4);
        check("s5_instr",     instr_b,        32'h9ABC);
        check("s5_pc",        pc_b,           32'h0);
        repeat (6) @(negedge clk);
        check("s5_retired", retired_b, 32'h1);
        check("s5_pc_next", pc_b,      32'h1);
        check("s5_busy",    busy_b,    32'h0);
        check("s5_halted",  halted_b,  32'h0);
        check("s5_err",     err_b,     32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitty_fetch_seq.md
# bitty_fetch_seq

Parametrised instruction-fetch sequencer for the Bitty core. It sequences PC → memory read → core execute → PC update with a configurable memory read latency. It adds features the fixed four-state run counter lacks: a branch-aware PC update, single-step mode, a HALT opcode, a core-done watchdog and a retired-instruction counter. It sits between the program memory, the branch logic and the `bitty` core inside the top-level wrapper.

## Interface
- `ADDR_W`, 8: PC / memory address width.
- `INSTR_W`, 16: instruction width.
- `MEM_LAT`, 1: memory read latency in cycles, ≥1.
- `RESET_PC`, 0: PC value after reset.
- `HALT_INSTR`, 16'hFFFF: opcode that stops sequencing.
- `TIMEOUT`, 255: max cycles waiting for `core_done`, ≥1.
- `CNT_W`, 16: retired counter width.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `run`  in  1: level enable (free-run mode) or step trigger (step mode).
- `step_mode`  in  1: 1 = one instruction per `run` rising edge.
- `mem_addr`  out  ADDR_W: read address, equals `pc`.
- `mem_rd`  out  1: read strobe, one cycle per fetch.
- `mem_rdata`  in  INSTR_W: read data, valid MEM_LAT cycles after `mem_rd`.
- `instr`  out  INSTR_W: latched instruction to core.
- `instr_valid`  out  1: one-cycle start pulse to core.
- `core_done`  in  1: core finished current instruction.
- `branch_taken`  in  1: sampled with `core_done`.
- `branch_pc`  in  ADDR_W: target, sampled with `core_done`.
- `pc`  out  ADDR_W: current PC.
- `busy`  out  1: state ≠ IDLE and ≠ HALT.
- `halted`  out  1: in HALT state.
- `err`  out  1: halted by watchdog timeout.
- `retired`  out  CNT_W: instructions completed.

## Operation
- States: IDLE, FETCH, EXEC, WAIT, HALT.
- IDLE: free-run mode → FETCH when `run`=1. Step mode → FETCH on a `run` 0→1 edge (registered previous `run`, cleared by reset).
- FETCH: `mem_rd`=1 in first cycle only. Internal latency counter runs for MEM_LAT further cycles. At end of the last cycle capture `mem_rdata` into `instr`.
  - If captured value == HALT_INSTR → HALT (no `instr_valid`, PC unchanged, `retired` unchanged).
  - Otherwise → EXEC.
- EXEC: `instr_valid`=1 for exactly this one cycle → WAIT. Watchdog counter cleared.
- WAIT: on `core_done`=1:
  - `pc` ← `branch_taken` ? `branch_pc` : `pc`+1, mod 2^ADDR_W (wraps, no flag).
  - `retired`+1, wraps to 0.
  - Next state: FETCH if `run`=1 and `step_mode`=0, else IDLE.
  - Without `core_done`, the watchdog increments. Reaching TIMEOUT → HALT with `err`=1; `pc` and `retired` unchanged.
- `core_done` is ignored outside WAIT.
- HALT: sticky; exits only via `reset`.
- `run` falling mid-instruction: the current instruction completes (fetch, execute, PC update), then IDLE.
- `step_mode` is sampled at the WAIT→next decision only.
- `instr` holds its value until the next capture.

## Timing
- Reset (synchronous, takes effect at the edge where `reset`=1, overrides everything including mid-FETCH/WAIT). Values after that edge:
  - `pc`=`mem_addr`=RESET_PC.
  - `mem_rd`=0, `instr`=0, `instr_valid`=0.
  - `busy`=0, `halted`=0, `err`=0, `retired`=0.
  - State IDLE.
- Free-run throughput per instruction: 1 (FETCH issue) + MEM_LAT + 1 (EXEC) + N, where N = cycles in WAIT including the `core_done` cycle. MEM_LAT=1 with `core_done` in first WAIT cycle → 4 cycles/instruction.
- `run` high at edge k in IDLE → `mem_rd`=1 in cycle k+1.
- `instr_valid` rises the cycle after `instr` is captured. `instr` is stable while `instr_valid`=1 and throughout WAIT.
- The new `pc` is visible the cycle after `core_done`; the next `mem_rd` is issued in that same cycle.
- Simultaneous `core_done` and watchdog terminal count: `core_done` wins.

## Test plan
- Reset then `run`=1, MEM_LAT=1, memory [0]=16'h1234, [1]=16'h5678, core returns `core_done` one cycle after `instr_valid` → `instr_valid` pulses with 16'h1234 then 16'h5678, 4 cycles apart; `pc` 0→1→2; `retired`=2.
- `core_done` with `branch_taken`=1, `branch_pc`=8'h40 → next `mem_addr`=8'h40. With ADDR_W=8 at `pc`=8'hFF, no branch → `pc` wraps to 8'h00.
- MEM_LAT=3 → `instr_valid` exactly 4 cycles after the `mem_rd` cycle, and `instr` equals `mem_rdata` sampled at latency 3.
- Memory [2]=HALT_INSTR → `halted`=1, `err`=0, `pc`=2, `instr_valid` never pulses for it, `retired`=2. `run` toggles are ignored until reset.
- `core_done` never asserted, TIMEOUT=255 → `halted`=1 and `err`=1 after 255 WAIT cycles; `pc` unchanged.
- `step_mode`=1, `run` held high → exactly one instruction, then IDLE. A second `run` 0→1 edge → one more. A `reset` pulse mid-WAIT → all outputs at reset values the next cycle.
